and_gate_arbiter: RTL and testbench



---
 rtl/and_gate_arbiter.sv | 111 +++++++++++
 tb/tb_and_gate_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/and_gate_arbiter.sv
// Round-robin arbiter that shares one registered WIDTH-bit AND unit among NREQ requesters.
// Each transaction occupies a 3-cycle slot: IDLE (grant) -> BUSY (evaluate) -> DONE (ack).
module and_gate_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      result,
    output logic                  busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   scan;
    logic [IW-1:0]   next_ptr;
    logic            found;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) sum = sum - NREQ;
        return IW'(sum);
    endfunction

    // Rotating-priority search: first set request at or after ptr, wrapping.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        scan  = ptr;
        for (int i = 0; i < NREQ; i++) begin
            scan = wrap_add(ptr, i);
            if (!found && req[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end

    assign next_ptr = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            winner <= '0;
            op_a   <= '0;
            op_b   <= '0;
            gnt    <= '0;
            ack    <= '0;
            result <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (found) begin
                        gnt    <= NREQ'(1) << pick;
                        busy   <= 1'b1;
                        winner <= pick;
                        op_a   <= a_in[pick*WIDTH +: WIDTH];
                        op_b   <= b_in[pick*WIDTH +: WIDTH];
                        state  <= BUSY;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                BUSY: begin
                    result <= op_a & op_b;
                    ack    <= gnt;
                    state  <= DONE;
                end
                DONE: begin
                    ptr   <= next_ptr;
                    gnt   <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_gate_arbiter.sv
// Self-checking bench for and_gate_arbiter: vector table plus hand-written multi-cycle sequences,
// with expected completions queued at drive time and compared when ack appears.
module tb_and_gate_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      result;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NREQ-1:0]  ack;
        logic [WIDTH-1:0] result;
    } item_t;

    typedef struct {
        logic [NREQ-1:0]       req;
        logic [NREQ*WIDTH-1:0] a;
        logic [NREQ*WIDTH-1:0] b;
        logic [NREQ-1:0]       exp_gnt;
        logic [WIDTH-1:0]      exp_result;
        logic [1:0]            exp_ptr;
    } vec_t;

    item_t sb[$];
    vec_t  vecs[8];
    logic [WIDTH-1:0] last_result;

    and_gate_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .a_in   (a_in),
        .b_in   (b_in),
        .gnt    (gnt),
        .ack    (ack),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [NREQ-1:0] r, input int win, input logic [1:0] p);
        vec_t v;
        v.req        = r;
        v.a          = $urandom;
        v.b          = $urandom;
        v.exp_gnt    = NREQ'(1 << win);
        v.exp_result = v.a[win*WIDTH +: WIDTH] & v.b[win*WIDTH +: WIDTH];
        v.exp_ptr    = p;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] slice_and(input int i);
        return a_in[i*WIDTH +: WIDTH] & b_in[i*WIDTH +: WIDTH];
    endfunction

    // Runs until every queued completion has been seen, dropping the acked
    // request bit (or all bits) on the edge that ends the ack cycle.
    task automatic serve(input int budget, input bit drop_all);
        logic [NREQ-1:0] drop = '0;
        int last = -1;
        int cyc  = 0;
        item_t e;
        while ((sb.size() > 0 || drop != '0) && cyc < budget) begin
            tick();
            cyc++;
            if (drop != '0) begin
                req  = req & ~drop;
                drop = '0;
            end
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 64'(ack), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("ack", 64'(ack), 64'(e.ack));
                    check("result", 64'(result), 64'(e.result));
                    check("gnt_during_ack", 64'(gnt), 64'(e.ack));
                    if (last >= 0) check("ack_spacing", 64'(cyc - last), 64'(3));
                    last = cyc;
                    drop = drop_all ? '1 : ack;
                end
            end
        end
        if (sb.size() > 0 || drop != '0) begin
            check("serve_timeout_pending", 64'(sb.size()), 64'(0));
            sb.delete();
            req = '0;
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;

        #7;
        check("reset_outputs", 64'({gnt, ack, busy, result}), 64'(0));
        check("reset_ptr", 64'(dut.ptr), 64'(0));
        #5 rst = 1'b0;
        tick();

        // Single request from reset.
        req  = 4'b0100;
        a_in = 32'hAAF0_5555;
        b_in = 32'hFF3C_FFFF;
        tick();
        check("single_gnt", 64'(gnt), 64'(4'b0100));
        check("single_busy", 64'(busy), 64'(1));
        check("single_no_early_ack", 64'(ack), 64'(0));
        tick();
        check("single_ack", 64'(ack), 64'(4'b0100));
        check("single_result", 64'(result), 64'(8'h30));
        tick();
        req = '0;
        check("single_ack_one_cycle", 64'(ack), 64'(0));
        check("single_idle", 64'({gnt, busy}), 64'(0));
        check("single_ptr", 64'(dut.ptr), 64'(3));
        check("single_result_held", 64'(result), 64'(8'h30));

        // Rotating-priority vectors starting from ptr=3; losers are released with the winner.
        vecs[0] = mk(4'b0011, 0, 2'd1);
        vecs[1] = mk(4'b0011, 1, 2'd2);
        vecs[2] = mk(4'b0110, 2, 2'd3);
        vecs[3] = mk(4'b1110, 3, 2'd0);
        vecs[4] = mk(4'b1000, 3, 2'd0);
        vecs[5] = mk(4'b0110, 1, 2'd2);
        vecs[6] = mk(4'b0001, 0, 2'd1);
        vecs[7] = mk(4'b1100, 2, 2'd3);
        for (int i = 0; i < 8; i++) begin
            req  = vecs[i].req;
            a_in = vecs[i].a;
            b_in = vecs[i].b;
            sb.push_back('{ack: vecs[i].exp_gnt, result: vecs[i].exp_result});
            serve(20, 1'b1);
            check($sformatf("vec%0d_ptr", i), 64'(dut.ptr), 64'(vecs[i].exp_ptr));
        end

        // Pointer wrap: ptr=3, requesters 3 and 0 both waiting.
        req  = 4'b1001;
        a_in = $urandom;
        b_in = $urandom;
        sb.push_back('{ack: 4'b1000, result: slice_and(3)});
        serve(20, 1'b0);
        check("wrap_ptr_after_3", 64'(dut.ptr), 64'(0));
        check("wrap_req0_still_held", 64'(req), 64'(4'b0001));
        sb.push_back('{ack: 4'b0001, result: slice_and(0)});
        serve(20, 1'b0);
        check("wrap_ptr_after_0", 64'(dut.ptr), 64'(1));

        // Full contention from a fresh reset: served 0,1,2,3 back to back.
        rst = 1'b1;
        #3 rst = 1'b0;
        check("contention_ptr_start", 64'(dut.ptr), 64'(0));
        req  = 4'b1111;
        a_in = $urandom;
        b_in = $urandom;
        for (int i = 0; i < NREQ; i++)
            sb.push_back('{ack: NREQ'(1 << i), result: slice_and(i)});
        serve(60, 1'b0);
        check("contention_all_released", 64'(req), 64'(0));
        check("contention_ptr_end", 64'(dut.ptr), 64'(0));

        // Operands and request change after capture.
        req  = 4'b0001;
        a_in = {24'h5A5A5A, 8'hFF};
        b_in = {24'hC3C3C3, 8'h0F};
        tick();
        check("opchg_gnt", 64'(gnt), 64'(4'b0001));
        a_in[7:0] = 8'h00;
        req       = '0;
        sb.push_back('{ack: 4'b0001, result: 8'h0F});
        serve(20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("opchg_no_extra_ack", 64'({ack, busy}), 64'(0));
        end
        check("opchg_ptr", 64'(dut.ptr), 64'(1));

        // Asynchronous reset during BUSY.
        req  = 4'b0100;
        a_in = 32'h00FF_0000;
        b_in = 32'h0077_0000;
        tick();
        check("rst_mid_busy_before", 64'(busy), 64'(1));
        #3 rst = 1'b1;
        #1;
        check("rst_mid_outputs", 64'({gnt, ack, busy, result}), 64'(0));
        check("rst_mid_ptr", 64'(dut.ptr), 64'(0));
        req = '0;
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_ack", 64'({ack, busy}), 64'(0));
        end
        req  = 4'b0010;
        a_in = $urandom;
        b_in = $urandom;
        last_result = slice_and(1);
        sb.push_back('{ack: 4'b0010, result: last_result});
        serve(20, 1'b0);
        check("rst_after_ptr", 64'(dut.ptr), 64'(2));

        // Idle stability with noisy operands.
        for (int i = 0; i < 20; i++) begin
            a_in = $urandom;
            b_in = $urandom;
            tick();
            check("idle_stable", 64'({gnt, ack, busy, result}), 64'({4'b0, 4'b0, 1'b0, last_result}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
